sys_bus_mem_slave: RTL

- Downstream system-bus slave that consumes the cache controller's read and write channels.
- Backs the bus with a word-addressed on-chip memory array.
- Inserts a programmable response latency so the cache's miss and write-through paths are exercised with realistic stalls.
- Single outstanding transaction; one read or one write in flight at a time.

---
 rtl/sys_bus_mem_slave_pkg.sv | 17 +
 rtl/sys_bus_mem_slave_if.sv | 40 ++++
 rtl/sys_bus_mem_slave_mem_array.sv | 36 +++
 rtl/sys_bus_mem_slave.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/sys_bus_mem_slave_pkg.sv
// Shared definitions for the system-bus memory slave: state codes,
// write-response codes and latency counter sizing.
package sys_bus_mem_slave_pkg;

    localparam int CNT_W = 8;
    typedef logic [CNT_W-1:0] lat_cnt_t;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_WAIT = 3'd1;
    localparam logic [2:0] S_RD_RESP = 3'd2;
    localparam logic [2:0] S_WR_WAIT = 3'd3;
    localparam logic [2:0] S_WR_RESP = 3'd4;

    localparam logic [31:0] RESP_OKAY   = 32'h0000_0000;
    localparam logic [31:0] RESP_SLVERR = 32'h0000_0001;

endpackage

// File: rtl/sys_bus_mem_slave_if.sv
// Read/write channel bundle between the cache controller (master) and the
// memory slave.
interface sys_bus_mem_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              readAddr_valid;
    logic              readAddr_ready;
    logic [ADDR_W-1:0] readAddr;
    logic              readData_valid;
    logic              readData_ready;
    logic [DATA_W-1:0] readData;
    logic              writeAddr_valid;
    logic              writeAddr_ready;
    logic [ADDR_W-1:0] writeAddr;
    logic              writeData_valid;
    logic              writeData_ready;
    logic [DATA_W-1:0] writeData;
    logic [3:0]        writeStrb;
    logic              writeResp_valid;
    logic              writeResp_ready;
    logic [31:0]       writeResp_msg;

    modport master (
        output readAddr_valid, readAddr, readData_ready,
        output writeAddr_valid, writeAddr, writeData_valid, writeData, writeStrb,
        output writeResp_ready,
        input  readAddr_ready, readData_valid, readData,
        input  writeAddr_ready, writeData_ready, writeResp_valid, writeResp_msg
    );

    modport slave (
        input  readAddr_valid, readAddr, readData_ready,
        input  writeAddr_valid, writeAddr, writeData_valid, writeData, writeStrb,
        input  writeResp_ready,
        output readAddr_ready, readData_valid, readData,
        output writeAddr_ready, writeData_ready, writeResp_valid, writeResp_msg
    );

endinterface

// File: rtl/sys_bus_mem_slave_mem_array.sv
// Word-wide synchronous RAM with one read port and one byte-strobed write
// port; read data only changes when i_rd_en is high.
module sys_bus_mem_array #(
    parameter int    DEPTH_LOG2 = 10,
    parameter int    DATA_W     = 32,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  i_rd_en,
    input  logic [DEPTH_LOG2-1:0] i_rd_idx,
    output logic [DATA_W-1:0]     o_rd_data,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_idx,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic [DATA_W/8-1:0]   i_wr_strb
);

    logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (i_wr_strb[b]) begin
                    r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sys_bus_mem_slave.sv
// System-bus memory slave: one outstanding read or write, programmable
// response latency, word-addressed on-chip memory behind it.
//
// state      | meaning
// S_IDLE     | readies live; write wins a same-cycle collision with a read
// S_RD_WAIT  | read latency countdown
// S_RD_RESP  | readData_valid held until readData_ready
// S_WR_WAIT  | write latency countdown (data already committed)
// S_WR_RESP  | writeResp_valid held until writeResp_ready
module sys_bus_mem_slave
    import sys_bus_mem_slave_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter int              DEPTH_LOG2 = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              RD_LAT     = 2,
    parameter int              WR_LAT     = 2,
    parameter string           INIT_FILE  = ""
) (
    input  logic                clk,
    input  logic                rst,
    sys_bus_mem_slave_if.slave  bus
);

    logic [2:0]            r_state;
    lat_cnt_t              r_cnt;
    logic [DEPTH_LOG2-1:0] r_rd_idx;
    logic                  r_rd_oor;
    logic [31:0]           r_resp_msg;

    logic [ADDR_W-1:0]     w_rd_off;
    logic [ADDR_W-1:0]     w_wr_off;
    logic                  w_rd_oor;
    logic                  w_wr_oor;
    logic [DEPTH_LOG2-1:0] w_rd_idx;
    logic [DEPTH_LOG2-1:0] w_wr_idx;
    logic                  w_idle;
    logic                  w_wr_req;
    logic                  w_wr_hs;
    logic                  w_rd_hs;
    logic                  w_cnt_done;
    logic                  w_mem_rd_en;
    logic [DEPTH_LOG2-1:0] w_mem_rd_idx;
    logic [DATA_W-1:0]     w_mem_q;
    logic                  w_unused_lsb;

    // Byte offsets below BASE_ADDR wrap to large values, hence the explicit compare.
    assign w_rd_off = bus.readAddr  - BASE_ADDR;
    assign w_wr_off = bus.writeAddr - BASE_ADDR;
    assign w_rd_oor = (bus.readAddr  < BASE_ADDR) || (w_rd_off[ADDR_W-1:DEPTH_LOG2+2] != '0);
    assign w_wr_oor = (bus.writeAddr < BASE_ADDR) || (w_wr_off[ADDR_W-1:DEPTH_LOG2+2] != '0);
    assign w_rd_idx = w_rd_off[DEPTH_LOG2+1:2];
    assign w_wr_idx = w_wr_off[DEPTH_LOG2+1:2];
    assign w_unused_lsb = ^{w_rd_off[1:0], w_wr_off[1:0]};

    assign w_idle   = (r_state == S_IDLE) && !rst;
    assign w_wr_req = bus.writeAddr_valid && bus.writeData_valid;
    assign w_wr_hs  = w_idle && w_wr_req;
    assign w_rd_hs  = w_idle && bus.readAddr_valid && !w_wr_req;

    assign bus.writeAddr_ready = w_wr_hs;
    assign bus.writeData_ready = w_wr_hs;
    assign bus.readAddr_ready  = w_rd_hs;

    assign w_cnt_done = (r_cnt == lat_cnt_t'(1));

    // The RAM is read exactly on the edge that enters S_RD_RESP so its output
    // stays stable for the whole response phase.
    assign w_mem_rd_en  = (w_rd_hs && (RD_LAT == 1)) ||
                          ((r_state == S_RD_WAIT) && w_cnt_done);
    assign w_mem_rd_idx = (r_state == S_IDLE) ? w_rd_idx : r_rd_idx;

    sys_bus_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W),
        .INIT_FILE  (INIT_FILE)
    ) u_mem (
        .clk       (clk),
        .i_rd_en   (w_mem_rd_en),
        .i_rd_idx  (w_mem_rd_idx),
        .o_rd_data (w_mem_q),
        .i_wr_en   (w_wr_hs && !w_wr_oor),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (bus.writeData),
        .i_wr_strb (bus.writeStrb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rd_idx   <= '0;
            r_rd_oor   <= 1'b0;
            r_resp_msg <= RESP_OKAY;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_hs) begin
                        r_resp_msg <= w_wr_oor ? RESP_SLVERR : RESP_OKAY;
                        r_cnt      <= lat_cnt_t'(WR_LAT - 1);
                        r_state    <= (WR_LAT == 1) ? S_WR_RESP : S_WR_WAIT;
                    end else if (w_rd_hs) begin
                        r_rd_idx <= w_rd_idx;
                        r_rd_oor <= w_rd_oor;
                        r_cnt    <= lat_cnt_t'(RD_LAT - 1);
                        r_state  <= (RD_LAT == 1) ? S_RD_RESP : S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    r_cnt <= r_cnt - lat_cnt_t'(1);
                    if (w_cnt_done) begin
                        r_state <= S_RD_RESP;
                    end
                end
                S_WR_WAIT: begin
                    r_cnt <= r_cnt - lat_cnt_t'(1);
                    if (w_cnt_done) begin
                        r_state <= S_WR_RESP;
                    end
                end
                S_RD_RESP: begin
                    if (bus.readData_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WR_RESP: begin
                    if (bus.writeResp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.readData_valid  = (r_state == S_RD_RESP);
    assign bus.readData        = ((r_state == S_RD_RESP) && !r_rd_oor) ? w_mem_q : '0;
    assign bus.writeResp_valid = (r_state == S_WR_RESP);
    assign bus.writeResp_msg   = r_resp_msg;

endmodule
